// File: rtl/ct_spsram_2048x32_ctrl_if.sv
// Client-side request/response bus of the single-port SRAM controller.
interface ct_spsram_2048x32_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                    req_vld;
  logic                    req_rdy;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_vld;
  logic                    rsp_rdy;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/ct_spsram_2048x32_ctrl.sv
// Single-port SRAM controller: optional zero-fill after reset, then valid/ready
// read/write access with a 2-entry read response FIFO.
module ct_spsram_2048x32_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ct_spsram_2048x32_ctrl_if.slave bus_if,
  output logic                    init_done_o,
  output logic [ADDR_WIDTH-1:0]   a_o,
  output logic                    cen_o,
  output logic                    gwen_o,
  output logic [DATA_WIDTH-1:0]   wen_o,
  output logic [DATA_WIDTH-1:0]   d_o,
  input  logic [DATA_WIDTH-1:0]   q_i
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            rsp_cnt_q, rsp_cnt_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];

  logic                  req_fire_s;
  logic                  rsp_pop_s;
  logic                  push_s;
  logic [2:0]            occ_s;

  assign req_fire_s = bus_if.req_vld & bus_if.req_rdy;
  assign rsp_pop_s  = bus_if.rsp_vld & bus_if.rsp_rdy;
  // A read is pushed into the FIFO the cycle after it fires, when Q is valid.
  assign push_s     = rd_inflight_q;
  assign occ_s      = {1'b0, rsp_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, rsp_pop_s};

  assign bus_if.req_rdy   = (state_q == ST_RUN) && (occ_s < 3'd2);
  assign bus_if.rsp_vld   = (rsp_cnt_q != 2'd0);
  assign bus_if.rsp_rdata = fifo_q[rd_ptr_q];
  assign init_done_o      = init_done_q;

  // Sequencer next state and zero-fill address counter.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_WAIT: begin
        state_d = INIT_EN ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // SRAM macro port: zero-fill writes in INIT, otherwise the accepted request.
  always_comb begin
    a_o    = '0;
    cen_o  = 1'b1;
    gwen_o = 1'b1;
    wen_o  = '1;
    d_o    = '0;
    if (state_q == ST_INIT) begin
      a_o    = init_cnt_q;
      cen_o  = 1'b0;
      gwen_o = 1'b0;
      wen_o  = '0;
    end else if (req_fire_s) begin
      a_o    = bus_if.req_addr;
      cen_o  = 1'b0;
      gwen_o = ~bus_if.req_wr;
      d_o    = bus_if.req_wdata;
      if (bus_if.req_wr) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          wen_o[8*i +: 8] = {8{~bus_if.req_be[i]}};
        end
      end else begin
        wen_o = '1;
      end
    end else begin
      a_o = '0;
    end
  end

  // Response FIFO bookkeeping.
  always_comb begin
    rd_inflight_d = req_fire_s & ~bus_if.req_wr;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = q_i;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rsp_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, rsp_pop_s})
      2'b10:   rsp_cnt_d = rsp_cnt_q + 2'd1;
      2'b01:   rsp_cnt_d = rsp_cnt_q - 2'd1;
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  // State, counter and FIFO registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_WAIT;
      init_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
      rsp_cnt_q     <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      init_done_q   <= init_done_d;
      rd_inflight_q <= rd_inflight_d;
      rsp_cnt_q     <= rsp_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_q[0]     <= fifo_d[0];
      fifo_q[1]     <= fifo_d[1];
    end
  end
endmodule

// File: tb/tb_ct_spsram_2048x32_ctrl.sv
// Directed bench for ct_spsram_2048x32_ctrl: zero-fill, table-driven accesses,
// back-pressure, resets mid-read and mid-fill, and the INIT_EN=0 variant.
module tb_ct_spsram_2048x32_ctrl;
  logic        clk;
  logic        rst;
  logic        fill_req;
  int          n_total;
  int          n_pass;
  int          d1_errs;

  logic        init_done0, init_done1;
  logic [10:0] a0, a1;
  logic        cen0, cen1, gwen0, gwen1;
  logic [31:0] wen0, wen1, d0, d1, q0;
  logic [31:0] mem [2048];

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] bp_data [8];

  ct_spsram_2048x32_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus0 ();
  ct_spsram_2048x32_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus1 ();

  ct_spsram_2048x32_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .INIT_EN(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus_if(bus0), .init_done_o(init_done0),
    .a_o(a0), .cen_o(cen0), .gwen_o(gwen0), .wen_o(wen0), .d_o(d0), .q_i(q0)
  );

  ct_spsram_2048x32_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .INIT_EN(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus_if(bus1), .init_done_o(init_done1),
    .a_o(a1), .cen_o(cen1), .gwen_o(gwen1), .wen_o(wen1), .d_o(d1), .q_i(32'h0000_0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM behavioural model: bit-masked write, read data valid the next cycle.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (!cen0) begin
      if (!gwen0) mem[a0] <= (mem[a0] & wen0) | (d0 & ~wen0);
      else        q0 <= mem[a0];
    end
  end

  // The INIT_EN=0 instance gets no requests, so its port must stay idle.
  always @(posedge clk) begin
    if (!rst && (!cen1 || !gwen1 || wen1 != 32'hFFFF_FFFF || a1 != 11'h000 ||
                 d1 != 32'h0 || bus1.rsp_vld || bus1.rsp_rdata != 32'h0))
      d1_errs <= d1_errs + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, 32'(bus0.req_rdy), 32'd0);
    check({tag, "_rsp_vld"}, 32'(bus0.rsp_vld), 32'd0);
    check({tag, "_rsp_rdata"}, bus0.rsp_rdata, 32'h0);
    check({tag, "_init_done"}, 32'(init_done0), 32'd0);
    check({tag, "_cen"}, 32'(cen0), 32'd1);
    check({tag, "_gwen"}, 32'(gwen0), 32'd1);
    check({tag, "_wen"}, wen0, 32'hFFFF_FFFF);
    check({tag, "_a"}, 32'(a0), 32'h0);
    check({tag, "_d"}, d0, 32'h0);
  endtask

  // Called in the first cycle after reset release; ends in the first RUN cycle.
  task automatic run_init_sweep(input string tag, input bit chk_d1);
    int errs = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk); #1;
      if (chk_d1 && i == 0) begin
        check("noinit_init_done_c2", 32'(init_done1), 32'd1);
        check("noinit_req_rdy_c2", 32'(bus1.req_rdy), 32'd1);
      end
      if (i == 0)    check({tag, "_first_a"}, 32'(a0), 32'h000);
      if (i == 2047) check({tag, "_last_a"}, 32'(a0), 32'h7FF);
      if (cen0 !== 1'b0 || gwen0 !== 1'b0 || wen0 !== 32'h0 || d0 !== 32'h0 ||
          a0 !== i[10:0] || bus0.req_rdy !== 1'b0 || init_done0 !== 1'b0 ||
          bus0.rsp_vld !== 1'b0)
        errs++;
    end
    check({tag, "_sweep_errs"}, 32'(errs), 32'd0);
    @(negedge clk); #1;
    check({tag, "_init_done"}, 32'(init_done0), 32'd1);
    check({tag, "_req_rdy"}, 32'(bus0.req_rdy), 32'd1);
    check({tag, "_idle_cen"}, 32'(cen0), 32'd1);
  endtask

  task automatic do_op(input string tag, input vec_t v);
    @(negedge clk);
    bus0.req_vld   = 1'b1;
    bus0.req_wr    = v.wr;
    bus0.req_addr  = v.addr;
    bus0.req_wdata = v.wdata;
    bus0.req_be    = v.be;
    bus0.rsp_rdy   = 1'b1;
    #1;
    check({tag, "_req_rdy"}, 32'(bus0.req_rdy), 32'd1);
    check({tag, "_cen"}, 32'(cen0), 32'd0);
    check({tag, "_gwen"}, 32'(gwen0), 32'(!v.wr));
    check({tag, "_a"}, 32'(a0), 32'(v.addr));
    check({tag, "_wen"}, wen0, v.exp_wen);
    if (v.wr) check({tag, "_d"}, d0, v.wdata);
    @(negedge clk);
    bus0.req_vld = 1'b0;
    #1;
    check({tag, "_idle_cen"}, 32'(cen0), 32'd1);
    check({tag, "_rsp_vld_n1"}, 32'(bus0.rsp_vld), 32'd0);
    @(negedge clk); #1;
    check({tag, "_rsp_vld_n2"}, 32'(bus0.rsp_vld), 32'(!v.wr));
    if (!v.wr) check({tag, "_rdata"}, bus0.rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    int   issued;
    int   popped;
    int   cyc;
    logic fire;
    vec_t v;

    vecs[0]  = '{1'b0, 11'h000, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{1'b0, 11'h7FF, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[2]  = '{1'b1, 11'h123, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 32'h0};
    vecs[3]  = '{1'b0, 11'h123, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 11'h7FF, 32'h1122_3344, 4'h3, 32'hFFFF_0000, 32'h0};
    vecs[5]  = '{1'b0, 11'h7FF, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'h0000_3344};
    vecs[6]  = '{1'b1, 11'h123, 32'hCAFE_F00D, 4'hA, 32'h00FF_00FF, 32'h0};
    vecs[7]  = '{1'b0, 11'h123, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'hCAAD_F0EF};
    vecs[8]  = '{1'b1, 11'h400, 32'h1234_5678, 4'h4, 32'hFF00_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 11'h400, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'h0034_0000};
    vecs[10] = '{1'b1, 11'h401, 32'hFFFF_FFFF, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, 11'h401, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b0, 11'h7FE, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'h0};
    bp_data  = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004,
                 32'h5000_0005, 32'h6000_0006, 32'h7000_0007, 32'h8000_0008};

    n_total = 0; n_pass = 0; d1_errs = 0;
    rst = 1'b1; fill_req = 1'b1;
    bus0.req_vld = 1'b0; bus0.req_wr = 1'b0; bus0.req_addr = 11'h0;
    bus0.req_wdata = 32'h0; bus0.req_be = 4'h0; bus0.rsp_rdy = 1'b1;
    bus1.req_vld = 1'b0; bus1.req_wr = 1'b0; bus1.req_addr = 11'h0;
    bus1.req_wdata = 32'h0; bus1.req_be = 4'h0; bus1.rsp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    fill_req = 1'b0;

    @(negedge clk); #1;
    check_reset_outputs("rst");
    check("rst_noinit_init_done", 32'(init_done1), 32'd0);

    // Release: this is cycle 1 after reset (WAIT).
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("c1_cen", 32'(cen0), 32'd1);
    check("c1_req_rdy", 32'(bus0.req_rdy), 32'd0);
    check("noinit_init_done_c1", 32'(init_done1), 32'd0);
    check("noinit_req_rdy_c1", 32'(bus1.req_rdy), 32'd0);
    run_init_sweep("init", 1'b1);

    for (int i = 0; i < 13; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // Write immediately followed by read of the same address.
    @(negedge clk);
    bus0.req_vld = 1'b1; bus0.req_wr = 1'b1; bus0.req_addr = 11'h055;
    bus0.req_wdata = 32'h0BAD_F00D; bus0.req_be = 4'hF;
    #1;
    check("wr_rd_wr_rdy", 32'(bus0.req_rdy), 32'd1);
    @(negedge clk);
    bus0.req_wr = 1'b0;
    #1;
    check("wr_rd_rd_rdy", 32'(bus0.req_rdy), 32'd1);
    check("wr_rd_rd_gwen", 32'(gwen0), 32'd1);
    @(negedge clk);
    bus0.req_vld = 1'b0;
    #1;
    check("wr_rd_vld_n1", 32'(bus0.rsp_vld), 32'd0);
    @(negedge clk); #1;
    check("wr_rd_vld_n2", 32'(bus0.rsp_vld), 32'd1);
    check("wr_rd_rdata", bus0.rsp_rdata, 32'h0BAD_F00D);
    @(negedge clk); #1;
    check("wr_rd_vld_n3", 32'(bus0.rsp_vld), 32'd0);

    // Eight back-to-back reads with the response side stalled for 5 cycles.
    for (int k = 0; k < 8; k++) begin
      v = '{1'b1, 11'h200 + 11'(k), bp_data[k], 4'hF, 32'h0, 32'h0};
      do_op($sformatf("bp_wr%0d", k), v);
    end
    issued = 0; popped = 0; cyc = 0;
    while ((issued < 8 || popped < 8) && cyc < 60) begin
      @(negedge clk);
      bus0.req_vld  = (issued < 8);
      bus0.req_wr   = 1'b0;
      bus0.req_addr = 11'h200 + 11'(issued);
      bus0.rsp_rdy  = (cyc >= 5);
      #1;
      if (cyc < 2) check($sformatf("bp_rdy_c%0d", cyc), 32'(bus0.req_rdy), 32'd1);
      if (cyc >= 2 && cyc <= 4) begin
        check($sformatf("bp_rdy_low_c%0d", cyc), 32'(bus0.req_rdy), 32'd0);
        check($sformatf("bp_hold_vld_c%0d", cyc), 32'(bus0.rsp_vld), 32'd1);
        check($sformatf("bp_hold_rdata_c%0d", cyc), bus0.rsp_rdata, bp_data[0]);
      end
      if (bus0.rsp_vld && bus0.rsp_rdy && popped < 8) begin
        check($sformatf("bp_rdata%0d", popped), bus0.rsp_rdata, bp_data[popped]);
        popped++;
      end
      fire = bus0.req_vld & bus0.req_rdy;
      @(posedge clk);
      if (fire) issued++;
      cyc++;
    end
    bus0.req_vld = 1'b0;
    bus0.rsp_rdy = 1'b1;
    check("bp_issued", 32'(issued), 32'd8);
    check("bp_popped", 32'(popped), 32'd8);
    @(negedge clk); #1;
    check("bp_drained", 32'(bus0.rsp_vld), 32'd0);

    // Reset while a read is in flight: its data must never appear.
    @(negedge clk);
    bus0.req_vld = 1'b1; bus0.req_wr = 1'b0; bus0.req_addr = 11'h123;
    @(negedge clk);
    bus0.req_vld = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_rd");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 1024; k++) @(negedge clk);
    #1;
    check("mid_init_a", 32'(a0), 32'h400);
    check("mid_init_cen", 32'(cen0), 32'd0);
    check("mid_init_rsp_vld", 32'(bus0.rsp_vld), 32'd0);

    // Reset in the middle of the zero-fill; the fill restarts from address 0.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reinit_c1_cen", 32'(cen0), 32'd1);
    run_init_sweep("reinit", 1'b0);
    v = '{1'b0, 11'h123, 32'h0, 4'h0, 32'hFFFF_FFFF, 32'h0};
    do_op("reinit_rd123", v);
    v = '{1'b0, 11'h055, 32'h0, 4'h0, 32'hFFFF_FFFF, 32'h0};
    do_op("reinit_rd055", v);

    @(negedge clk); #1;
    check("noinit_no_access", 32'(d1_errs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
